gcd_sched: RTL and testbench
============================

Name: gcd_sched

Overview:
- Round-robin scheduler that shares one `gcd_top` engine between NUM_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The scheduler issues the pair to the engine and returns the result on a shared response port tagged with the requester index.
- It also short-circuits zero operands, because the engine never terminates when x=0 and y≠0.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DW, 32: operand/result width; must match the engine.
- IDW, 2: response ID width, equal to clog2(NUM_REQ).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  request valid per requester.
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero).
- req_x  in  NUM_REQ*DW  packed operand x; requester i occupies bits [i*DW +: DW].
- req_y  in  NUM_REQ*DW  packed operand y, same packing.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  requester index of the response.
- rsp_gcd  out  DW  result.
- eng_start  out  1  engine start pulse.
- eng_x  out  DW  engine operand x.
- eng_y  out  DW  engine operand y.
- eng_gcd  in  DW  engine result.
- eng_done  in  1  engine done; sticky high until the engine's next start is accepted.

Behaviour:
- Reset values: state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_gcd=0, eng_start=0, eng_x=0, eng_y=0, rr pointer=NUM_REQ-1 (so requester 0 has first priority).
- The parent drives the engine's synchronous active-high reset from the same source as ~rst_n.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant g = first i with req_valid[i], searching upward from rr_ptr+1 modulo NUM_REQ.
  - req_ready[g]=1 combinationally; handshake completes in the same cycle.
  - On transfer, capture x/y into eng_x/eng_y, set cur_id=g and rr_ptr=g.
  - If x==0 or y==0: rsp_gcd <= x|y, go to RESP; the engine is untouched (covers 0,0 -> 0).
  - Otherwise go to ISSUE.
  - eng_done is ignored in IDLE; a stale high level is legal.
- ISSUE: eng_start=1 for exactly this cycle; go to WAIT unconditionally.
- WAIT:
  - Because the engine clears done on the edge that samples start, any done seen in WAIT is genuine.
  - When eng_done=1: rsp_gcd <= eng_gcd, go to RESP.
  - No timeout: nonzero operands always terminate.
- RESP:
  - rsp_valid=1 with rsp_id=cur_id.
  - rsp_gcd and rsp_id are held stable while rsp_ready=0.
  - On rsp_valid&rsp_ready, go to IDLE.
  - req_ready is 0 in every state except IDLE.
- Latency with rsp_ready tied high and nonzero operands: accept at edge T; eng_start in cycle T+1; rsp_valid one cycle after eng_done is first seen.
- Latency for a zero-operand bypass: rsp_valid in cycle T+1.
- Fairness: a requester held valid waits at most NUM_REQ-1 other transactions.
- Simultaneous events:
  - A new request arriving during ISSUE/WAIT/RESP stays pending; it is never lost or reordered against the rr order.
  - A request that drops req_valid before it is granted is simply skipped.
- Reset mid-operation: any state returns to IDLE asynchronously, the captured transaction is discarded, and no response is produced.
- Widths: the result is carried at DW bits; no arithmetic is performed in the scheduler beyond x|y.

Decomposition:
- Shared include/package `gcd_pkg`:
  - state encoding localparams S_IDLE=0, S_ISSUE=1, S_WAIT=2, S_RESP=3;
  - DW default.
- One natural sub-module, `rr_arbiter`:
  - parameter N;
  - inputs: req[N], ptr;
  - outputs: one-hot grant[N], grant_idx, any;
  - purely combinational.
- FSM, capture registers and response registers live in `gcd_sched`.

Test Plan:
- Single request: req0 x=48,y=18, rsp_ready=1 -> eng_start one cycle after accept; rsp_id=0, rsp_gcd=6; exactly one rsp_valid cycle.
- Zero bypass:
  - req1 x=0,y=35 -> rsp_gcd=35, rsp_id=1, eng_start never asserted.
  - x=0,y=0 -> rsp_gcd=0.
  - x=21,y=0 -> rsp_gcd=21.
- Round-robin: all four valid continuously with (12,8),(9,6),(10,4),(7,3) -> responses in order id 0,1,2,3 with gcd 4,3,2,1; then id 0 again; no requester is skipped.
- Backpressure: rsp_ready=0 for 5 cycles on (100,75) -> rsp_valid held; rsp_gcd=25 stable; req_ready all 0; a pending req2 is accepted only after the rsp handshake.
- Stale done: a second transaction on (17,5) issued immediately after a completed one -> no early response; rsp_gcd=1, not the previous result.
- Reset in WAIT: rst_n pulsed low during (1000,3) -> outputs return to reset values immediately; no rsp_valid; next request (8,12) returns 4 with id 0 first priority.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD request scheduler.
// State encoding and the default operand width.
package gcd_pkg;

  localparam int GCD_DW = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } gcd_state_t;

endpackage

// File: rtl/gcd_sched_if.sv
// Request, response and engine signals of the GCD scheduler.
// master: the scheduler side; slave: requesters, consumer and engine.
interface gcd_sched_if
  import gcd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DW      = GCD_DW,
  parameter int IDW     = 2
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*DW-1:0] req_x;
  logic [NUM_REQ*DW-1:0] req_y;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [DW-1:0]         rsp_gcd;

  logic                  eng_start;
  logic [DW-1:0]         eng_x;
  logic [DW-1:0]         eng_y;
  logic [DW-1:0]         eng_gcd;
  logic                  eng_done;

  modport master (
    input  req_valid,
    input  req_x,
    input  req_y,
    input  rsp_ready,
    input  eng_gcd,
    input  eng_done,
    output req_ready,
    output rsp_valid,
    output rsp_id,
    output rsp_gcd,
    output eng_start,
    output eng_x,
    output eng_y
  );

  modport slave (
    output req_valid,
    output req_x,
    output req_y,
    output rsp_ready,
    output eng_gcd,
    output eng_done,
    input  req_ready,
    input  rsp_valid,
    input  rsp_id,
    input  rsp_gcd,
    input  eng_start,
    input  eng_x,
    input  eng_y
  );

endinterface

// File: rtl/gcd_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches upward from ptr+1 modulo N for the first active request.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  int w_j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    w_j       = 0;
    for (int k = 1; k <= N; k++) begin
      w_j = (int'(ptr) + k) % N;
      if (!any && req[w_j]) begin
        any        = 1'b1;
        grant[w_j] = 1'b1;
        grant_idx  = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/gcd_sched.sv
// Round-robin scheduler sharing one GCD engine between requesters.
// Zero operands bypass the engine, which would never terminate on them.
module gcd_sched
  import gcd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DW      = GCD_DW,
  parameter int IDW     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  gcd_sched_if.master bus
);

  gcd_state_t         r_state;
  gcd_state_t         w_next;

  logic [IDW-1:0]     r_rr_ptr;
  logic [IDW-1:0]     r_cur_id;
  logic [DW-1:0]      r_eng_x;
  logic [DW-1:0]      r_eng_y;
  logic [DW-1:0]      r_rsp_gcd;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDW-1:0]     w_gidx;
  logic               w_any;
  logic               w_idle;
  logic               w_take;
  logic               w_zero;
  logic [DW-1:0]      w_x;
  logic [DW-1:0]      w_y;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_arb (
    .req       (bus.req_valid),
    .ptr       (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_gidx),
    .any       (w_any)
  );

  assign w_x = bus.req_x[int'(w_gidx)*DW +: DW];
  assign w_y = bus.req_y[int'(w_gidx)*DW +: DW];

  // ready stays low while reset is held, even though IDLE is reached
  assign w_idle = (r_state == S_IDLE) && rst_n;
  assign w_take = w_idle && w_any;
  assign w_zero = (w_x == '0) || (w_y == '0);

  assign bus.req_ready = w_idle ? w_grant : '0;
  assign bus.eng_start = (r_state == S_ISSUE);
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_id    = r_cur_id;
  assign bus.rsp_gcd   = r_rsp_gcd;
  assign bus.eng_x     = r_eng_x;
  assign bus.eng_y     = r_eng_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_take) begin
          w_next = w_zero ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (bus.eng_done) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr  <= IDW'(NUM_REQ - 1);
      r_cur_id  <= '0;
      r_eng_x   <= '0;
      r_eng_y   <= '0;
      r_rsp_gcd <= '0;
    end else begin
      if (w_take) begin
        r_eng_x  <= w_x;
        r_eng_y  <= w_y;
        r_cur_id <= w_gidx;
        r_rr_ptr <= w_gidx;
        if (w_zero) begin
          r_rsp_gcd <= w_x | w_y;
        end
      end
      if (r_state == S_WAIT && bus.eng_done) begin
        r_rsp_gcd <= bus.eng_gcd;
      end
    end
  end

endmodule

// File: tb/tb_gcd_sched.sv
// Scoreboard bench for gcd_sched with a subtractive engine model.
// Expected results come from a modulo-based reference gcd.
module tb_gcd_sched;
  import gcd_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int IDW = 2;

  typedef struct packed {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
  } pair_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  g;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gcd_sched_if #(
    .NUM_REQ (N),
    .DW      (DW),
    .IDW     (IDW)
  ) bus ();

  gcd_sched #(
    .NUM_REQ (N),
    .DW      (DW),
    .IDW     (IDW)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int n_start = 0;
  int n_rv = 0;
  logic acc_zero = 1'b0;
  logic rsp_seen = 1'b0;
  logic [N-1:0] v = '0;
  logic [N-1:0] acc = '0;
  logic rdy = 1'b1;
  logic [DW-1:0] sx [N];
  logic [DW-1:0] sy [N];
  logic [DW-1:0] last_gcd = '0;
  logic [IDW-1:0] last_id = '0;
  pair_t sq [N][$];
  exp_t exp_q [$];
  int acc_log [$];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] ref_gcd(logic [DW-1:0] a,
                                            logic [DW-1:0] b);
    logic [DW-1:0] t;
    while (b != '0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // requester-side wiring
  assign bus.req_valid = v;
  assign bus.rsp_ready = rdy;
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign bus.req_x[g*DW +: DW] = sx[g];
    assign bus.req_y[g*DW +: DW] = sy[g];
  end

  // engine model: one subtraction step per cycle, sticky done
  logic [DW-1:0] ea, eb, eg;
  logic ed, ebusy;
  always @(posedge clk) begin
    if (!rst_n) begin
      ed <= 1'b0; ebusy <= 1'b0;
      ea <= '0; eb <= '0; eg <= '0;
    end else if (bus.eng_start) begin
      ed <= 1'b0; ebusy <= 1'b1;
      ea <= bus.eng_x; eb <= bus.eng_y;
    end else if (ebusy) begin
      if (ea == eb) begin
        ed <= 1'b1; eg <= ea; ebusy <= 1'b0;
      end else if (ea > eb) ea <= ea - eb;
      else eb <= eb - ea;
    end
  end
  assign bus.eng_done = ed;
  assign bus.eng_gcd  = eg;

  always @(posedge clk) cyc++;

  // driver: drop accepted requests, load next pair
  always @(posedge clk) begin
    pair_t p;
    #1;
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        v[i] = 1'b0;
        sq[i].delete();
      end else begin
        if (acc[i]) v[i] = 1'b0;
        if (!v[i] && sq[i].size() > 0) begin
          p = sq[i].pop_front();
          sx[i] = p.x;
          sy[i] = p.y;
          v[i] = 1'b1;
        end
      end
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    acc = rst_n ? (bus.req_valid & bus.req_ready) : '0;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      chk("rdy_1hot", 64'($onehot0(bus.req_ready)), 64'd1);
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          exp_q.push_back('{id: IDW'(i), g: ref_gcd(sx[i], sy[i])});
          acc_log.push_back(i);
          acc_cyc = cyc;
          acc_zero = (sx[i] == '0) || (sy[i] == '0);
          rsp_seen = 1'b0;
        end
      end
      if (bus.eng_start) begin
        n_start++;
        chk("start_lat", 64'(cyc - acc_cyc), 64'd1);
      end
      if (bus.rsp_valid) begin
        n_rv++;
        if (!rsp_seen) begin
          rsp_seen = 1'b1;
          if (acc_zero) chk("byp_lat", 64'(cyc - acc_cyc), 64'd1);
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexp", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
          chk("rsp_gcd", 64'(bus.rsp_gcd), 64'(e.g));
          last_id = bus.rsp_id;
          last_gcd = bus.rsp_gcd;
        end
      end
    end
  end

  task automatic push(int i, logic [DW-1:0] x, logic [DW-1:0] y);
    sq[i].push_back('{x: x, y: y});
  endtask

  function automatic logic busy_tb();
    logic b;
    b = (v != '0) || (exp_q.size() != 0);
    for (int i = 0; i < N; i++) if (sq[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_idle(int budget);
    int k;
    k = 0;
    @(posedge clk);
    while (busy_tb() && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (k >= budget) chk("timeout", 64'd1, 64'd0);
    repeat (2) @(posedge clk);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_rdy"}, 64'(bus.req_ready), 64'd0);
    chk({tag, "_rv"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_rid"}, 64'(bus.rsp_id), 64'd0);
    chk({tag, "_rg"}, 64'(bus.rsp_gcd), 64'd0);
    chk({tag, "_st"}, 64'(bus.eng_start), 64'd0);
    chk({tag, "_ex"}, 64'(bus.eng_x), 64'd0);
    chk({tag, "_ey"}, 64'(bus.eng_y), 64'd0);
  endtask

  initial begin
    int s0, rv0, base, k;
    for (int i = 0; i < N; i++) begin
      sx[i] = '0;
      sy[i] = '0;
    end
    #1;
    chk_reset_vals("rst0");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // single request with engine
    s0 = n_start; rv0 = n_rv;
    push(0, 48, 18);
    wait_idle(500);
    chk("t1_starts", 64'(n_start - s0), 64'd1);
    chk("t1_rvcyc", 64'(n_rv - rv0), 64'd1);
    chk("t1_gcd", 64'(last_gcd), 64'd6);
    chk("t1_id", 64'(last_id), 64'd0);

    // zero-operand bypass
    s0 = n_start;
    push(1, 0, 35);
    wait_idle(100);
    chk("byp1_gcd", 64'(last_gcd), 64'd35);
    chk("byp1_id", 64'(last_id), 64'd1);
    push(1, 0, 0);
    wait_idle(100);
    chk("byp2_gcd", 64'(last_gcd), 64'd0);
    push(3, 21, 0);
    wait_idle(100);
    chk("byp3_gcd", 64'(last_gcd), 64'd21);
    chk("byp_starts", 64'(n_start - s0), 64'd0);

    // round robin, all four continuously valid
    base = acc_log.size();
    for (int r = 0; r < 2; r++) begin
      push(0, 12, 8);
      push(1, 9, 6);
      push(2, 10, 4);
      push(3, 7, 3);
    end
    wait_idle(2000);
    chk("rr_cnt", 64'(acc_log.size() - base), 64'd8);
    for (int j = 0; j < 8; j++) begin
      if (base + j < acc_log.size())
        chk("rr_order", 64'(acc_log[base + j]), 64'(j % N));
    end

    // response backpressure
    base = acc_log.size();
    @(posedge clk); #1 rdy = 1'b0;
    push(0, 100, 75);
    k = 0;
    while (!bus.rsp_valid && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) chk("bp_timeout", 64'd1, 64'd0);
    push(2, 9, 3);
    repeat (5) begin
      @(negedge clk);
      chk("bp_rv", 64'(bus.rsp_valid), 64'd1);
      chk("bp_gcd", 64'(bus.rsp_gcd), 64'd25);
      chk("bp_id", 64'(bus.rsp_id), 64'd0);
      chk("bp_rdy", 64'(bus.req_ready), 64'd0);
    end
    @(posedge clk); #1 rdy = 1'b1;
    wait_idle(500);
    chk("bp_cnt", 64'(acc_log.size() - base), 64'd2);
    if (acc_log.size() >= base + 2) begin
      chk("bp_first", 64'(acc_log[base]), 64'd0);
      chk("bp_second", 64'(acc_log[base + 1]), 64'd2);
    end

    // back-to-back with stale done
    s0 = n_start;
    push(1, 35, 14);
    push(1, 17, 5);
    wait_idle(500);
    chk("stale_gcd", 64'(last_gcd), 64'd1);
    chk("stale_starts", 64'(n_start - s0), 64'd2);

    // reset while waiting on the engine
    s0 = n_start; rv0 = n_rv;
    push(2, 1000, 3);
    k = 0;
    while (n_start == s0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("rw_timeout", 64'd1, 64'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_reset_vals("rstw");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    chk("rstw_norsp", 64'(n_rv - rv0), 64'd0);
    base = acc_log.size();
    push(3, 8, 12);
    push(0, 8, 12);
    wait_idle(500);
    chk("rstw_cnt", 64'(acc_log.size() - base), 64'd2);
    if (acc_log.size() > base)
      chk("rstw_first", 64'(acc_log[base]), 64'd0);
    chk("rstw_gcd", 64'(last_gcd), 64'd4);

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1);
  end

endmodule
